// File: rtl/bcd_complementer_seq.sv
// ============================================================================
// Module   : bcd_complementer_seq
// Brief    : Digit-serial 9's/10's complementer for packed BCD, LSD first.
//            Define BCDC_TENS_EN to build the 10's-complement carry path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_complementer_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   din,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   dout,
    output logic                  err
);

    localparam int c_width = 4 * DIGITS;
    localparam int c_cnt_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_width-1:0]   r_opnd;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_err_acc;
    logic                 r_busy;
    logic                 r_done;
    logic [c_width-1:0]   r_dout;
    logic                 r_err;

    logic [3:0]           w_digit_in;
    logic [3:0]           w_digit_out;
    logic                 w_bad;
    logic                 w_run;
    logic [c_width-1:0]   w_res_next;

    assign w_digit_in = r_opnd[3:0];
    assign w_bad      = (w_digit_in > 4'd9);
    assign w_run      = (r_state == RUN);

`ifdef BCDC_TENS_EN
    logic       r_carry;
    logic       w_carry_next;
    logic [4:0] w_sum;

    // An invalid digit kills the carry so it cannot leak into higher digits.
    always_comb begin
        w_sum        = {1'b0, 4'd9 - w_digit_in} + {4'd0, r_carry};
        w_carry_next = 1'b0;
        w_digit_out  = w_sum[3:0];
        if (w_bad) begin
            w_digit_out = 4'hF;
        end else if (w_sum == 5'd10) begin
            w_digit_out  = 4'd0;
            w_carry_next = 1'b1;
        end
    end
`else
    logic w_unused_mode;

    assign w_unused_mode = mode;

    always_comb begin
        w_digit_out = 4'd9 - w_digit_in;
        if (w_bad) begin
            w_digit_out = 4'hF;
        end
    end
`endif

    // New digits enter at the top, so after DIGITS shifts the LSD sits at [3:0].
    generate
        if (DIGITS == 1) begin : g_res_single
            assign w_res_next = w_digit_out;
        end else begin : g_res_multi
            logic [c_width-5:0] r_res;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_res <= '0;
                end else if (w_run) begin
                    r_res <= w_res_next[c_width-1:4];
                end
            end

            assign w_res_next = {w_digit_out, r_res};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_opnd    <= '0;
            r_cnt     <= '0;
            r_err_acc <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dout    <= '0;
            r_err     <= 1'b0;
`ifdef BCDC_TENS_EN
            r_carry   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_opnd    <= din;
                        r_cnt     <= '0;
                        r_err_acc <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
`ifdef BCDC_TENS_EN
                        r_carry   <= mode;
`endif
                    end
                end
                RUN: begin
                    r_opnd    <= r_opnd >> 4;
                    r_cnt     <= r_cnt + 1'b1;
                    r_err_acc <= r_err_acc | w_bad;
`ifdef BCDC_TENS_EN
                    r_carry   <= w_carry_next;
`endif
                    if (r_cnt == c_last_cnt) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_dout  <= w_res_next;
                        r_err   <= r_err_acc | w_bad;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dout = r_dout;
    assign err  = r_err;

endmodule

`default_nettype wire
